// File: rtl/jedro_1_defines.sv
// Shared constants and types for the jedro_1 instruction fetch path.
package jedro_1_defines;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned ILEN    = 32;
    localparam int unsigned ENTRY_W = XLEN + ILEN;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StFlush
    } ifu_state_e;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/jedro_1_fetch_fifo.sv
// Prefetch buffer holding {pc, instruction} pairs; power-of-two depth, flush clears occupancy.
module jedro_1_fetch_fifo
    import jedro_1_defines::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               push_i,
    input  logic [ENTRY_W-1:0] push_data_i,
    input  logic               pop_i,
    input  logic               flush_i,
    output logic [ENTRY_W-1:0] head_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [CNT_W-1:0]   count_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]    wptr_q, rptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               push_ok, pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rptr_q];

    // A pop frees the slot a same-cycle push into a full buffer needs; no empty bypass.
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wptr_q] <= push_data_i;
                wptr_q        <= wptr_q + PtrW'(1);
            end
            if (pop_ok) begin
                rptr_q <= rptr_q + PtrW'(1);
            end
            count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/jedro_1_ifu.sv
// Instruction fetch unit: single-outstanding bus master feeding a prefetch buffer,
// with redirect (jump) handling that discards in-flight responses.
module jedro_1_ifu
    import jedro_1_defines::*;
#(
    parameter logic [XLEN-1:0] BOOT_ADDR  = 32'h0000_0000,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            en_i,
    input  logic            jmp_i,
    input  logic [XLEN-1:0] jmp_addr_i,
    output logic            instr_req_o,
    input  logic            instr_gnt_i,
    output logic [XLEN-1:0] instr_addr_o,
    input  logic            instr_rvalid_i,
    input  logic [ILEN-1:0] instr_rdata_i,
    output logic            dec_valid_o,
    input  logic            dec_ready_i,
    output logic [ILEN-1:0] dec_instr_o,
    output logic [XLEN-1:0] dec_pc_o
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    ifu_state_e         state_q;
    logic [XLEN-1:0]    pc_q, addr_q, pc_nxt;
    logic               kill_q, started_q;
    logic               push, pop, room;
    logic               fifo_empty, unused_full;
    logic [CntW-1:0]    count, count_nxt;
    logic [ENTRY_W-1:0] head;

    assign pop  = ~fifo_empty & dec_ready_i;
    assign push = (state_q == StWait) & instr_rvalid_i & ~jmp_i;

    // Occupancy after this edge; a request may only issue if its response will fit.
    always_comb begin
        count_nxt = count;
        if (jmp_i) begin
            count_nxt = '0;
        end else begin
            count_nxt = count + CntW'(push) - CntW'(pop);
        end
    end

    assign room = (count_nxt < CntW'(FIFO_DEPTH));

    // kill_q means pc_q already holds a redirect target, so the grant must not bump it.
    always_comb begin
        pc_nxt = pc_q;
        if (jmp_i) begin
            pc_nxt = word_align(jmp_addr_i);
        end else if (state_q == StReq && instr_gnt_i && !kill_q) begin
            pc_nxt = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= StIdle;
            pc_q      <= BOOT_ADDR;
            addr_q    <= BOOT_ADDR;
            kill_q    <= 1'b0;
            started_q <= 1'b0;
        end else begin
            started_q <= 1'b1;
            pc_q      <= pc_nxt;
            case (state_q)
                StIdle: begin
                    if (started_q && en_i && room) begin
                        state_q <= StReq;
                        addr_q  <= pc_nxt;
                    end
                end
                StReq: begin
                    if (instr_gnt_i) begin
                        state_q <= (jmp_i || kill_q) ? StFlush : StWait;
                        kill_q  <= 1'b0;
                    end else if (jmp_i) begin
                        kill_q <= 1'b1;
                    end
                end
                StWait, StFlush: begin
                    if (instr_rvalid_i) begin
                        if (en_i && room) begin
                            state_q <= StReq;
                            addr_q  <= pc_nxt;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else if (jmp_i) begin
                        state_q <= StFlush;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign instr_req_o  = (state_q == StReq);
    assign instr_addr_o = addr_q;

    jedro_1_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CntW)
    ) u_fifo (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .push_i      (push),
        .push_data_i ({addr_q, instr_rdata_i}),
        .pop_i       (pop),
        .flush_i     (jmp_i),
        .head_o      (head),
        .full_o      (unused_full),
        .empty_o     (fifo_empty),
        .count_o     (count)
    );

    assign dec_valid_o = ~fifo_empty;
    assign dec_pc_o    = head[ENTRY_W-1:ILEN];
    assign dec_instr_o = head[ILEN-1:0];

endmodule

// File: tb/tb_jedro_1_ifu.sv
// Scoreboard bench for jedro_1_ifu: a bus responder checks request addresses and a
// decoder monitor checks delivered {pc, instr} against queues filled by directed tests.
module tb_jedro_1_ifu;

    localparam logic [31:0] HiBoot = 32'hFFFF_FFF8;

    logic        clk = 1'b0, rstn = 1'b0, en = 1'b0, jmp = 1'b0, sel = 1'b0;
    logic        gnt = 1'b0, rvalid = 1'b0, dec_ready = 1'b0;
    logic [31:0] jmp_addr = '0, rdata = '0;

    logic        req_lo, req_hi, dv_lo, dv_hi;
    logic [31:0] addr_lo, addr_hi, di_lo, di_hi, dp_lo, dp_hi;
    logic        req_m, dv_m;
    logic [31:0] addr_m, di_m, dp_m;

    int          checks = 0, passes = 0, hs_count = 0;
    logic [31:0] exp_addr[$];
    logic [63:0] exp_dec[$];
    bit          auto_gnt = 0, auto_rvalid = 0, mode13 = 0, pend = 0;
    logic [31:0] pend_addr = '0;

    always #5 clk = ~clk;

    jedro_1_ifu dut_lo (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .en_i           (en),
        .jmp_i          (jmp),
        .jmp_addr_i     (jmp_addr),
        .instr_req_o    (req_lo),
        .instr_gnt_i    (gnt & ~sel),
        .instr_addr_o   (addr_lo),
        .instr_rvalid_i (rvalid & ~sel),
        .instr_rdata_i  (rdata),
        .dec_valid_o    (dv_lo),
        .dec_ready_i    (dec_ready),
        .dec_instr_o    (di_lo),
        .dec_pc_o       (dp_lo)
    );

    jedro_1_ifu #(
        .BOOT_ADDR (HiBoot)
    ) dut_hi (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .en_i           (en),
        .jmp_i          (jmp),
        .jmp_addr_i     (jmp_addr),
        .instr_req_o    (req_hi),
        .instr_gnt_i    (gnt & sel),
        .instr_addr_o   (addr_hi),
        .instr_rvalid_i (rvalid & sel),
        .instr_rdata_i  (rdata),
        .dec_valid_o    (dv_hi),
        .dec_ready_i    (dec_ready),
        .dec_instr_o    (di_hi),
        .dec_pc_o       (dp_hi)
    );

    assign req_m  = sel ? req_hi  : req_lo;
    assign addr_m = sel ? addr_hi : addr_lo;
    assign dv_m   = sel ? dv_hi   : dv_lo;
    assign di_m   = sel ? di_hi   : di_lo;
    assign dp_m   = sel ? dp_hi   : dp_lo;

    function automatic logic [31:0] data_fn(input logic [31:0] a, input bit m13);
        return m13 ? 32'h0000_0013 : ({a[15:0], a[31:16]} ^ 32'h5A5A_C3C3);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Bus responder: grants at negedge for the following posedge, answers one cycle later.
    initial begin
        forever begin
            @(negedge clk);
            if (!rstn) begin
                pend = 0; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
            end else begin
                if (pend && auto_rvalid) begin
                    rvalid = 1'b1; rdata = data_fn(pend_addr, mode13); pend = 0;
                end else begin
                    rvalid = 1'b0; rdata = '0;
                end
                gnt = auto_gnt;
                if (req_m && auto_gnt) begin
                    if (exp_addr.size() == 0) begin
                        checks++;
                        $display("FAIL bus_extra: got request at %h, none expected", addr_m);
                    end else begin
                        check("bus_addr", addr_m, exp_addr.pop_front());
                    end
                    pend = 1; pend_addr = addr_m; hs_count++;
                end
            end
        end
    end

    // Decoder monitor.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (rstn && dv_m && dec_ready) begin
                if (exp_dec.size() == 0) begin
                    checks++;
                    $display("FAIL dec_extra: got pc %h, none expected", dp_m);
                end else begin
                    e = exp_dec.pop_front();
                    check("dec_pc", dp_m, e[63:32]);
                    check("dec_instr", di_m, e[31:0]);
                end
            end
        end
    end

    task automatic push_exp(input logic [31:0] a, input bit to_dec);
        exp_addr.push_back(a);
        if (to_dec) exp_dec.push_back({a, data_fn(a, mode13)});
    endtask

    task automatic do_reset(input bit s, input logic [31:0] boot, input bit m13);
        @(posedge clk); #1;
        rstn = 1'b0; en = 1'b0; jmp = 1'b0; jmp_addr = '0; dec_ready = 1'b0;
        auto_gnt = 0; auto_rvalid = 0; sel = s; mode13 = m13;
        exp_addr.delete(); exp_dec.delete();
        repeat (2) @(posedge clk); #1;
        check("rst_req", 32'(req_m), 32'd0);
        check("rst_addr", addr_m, boot);
        check("rst_dec_valid", 32'(dv_m), 32'd0);
        check("rst_dec_instr", di_m, 32'd0);
        check("rst_dec_pc", dp_m, 32'd0);
    endtask

    task automatic wait_hs(input string name);
        int start = hs_count;
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            if (hs_count != start) begin ok = 1; break; end
        end
        #1;
        check({"handshake_", name}, 32'(ok), 32'd1);
    endtask

    task automatic settle_stalled(input string name);
        repeat (20) @(posedge clk); #1;
        check({"stall_req_", name}, 32'(req_m), 32'd0);
    endtask

    task automatic drain(input string name);
        en = 1'b0; dec_ready = 1'b1;
        repeat (12) @(posedge clk); #1;
        check({"dec_left_", name}, 32'(exp_dec.size()), 32'd0);
        check({"bus_left_", name}, 32'(exp_addr.size()), 32'd0);
        dec_ready = 1'b0;
    endtask

    // Fill a two-deep buffer with the decoder stalled, then free one slot with a single pop.
    task automatic run_stream(input bit s, input logic [31:0] boot, input bit m13);
        logic [31:0] a1, a2;
        a1 = boot + 32'd4;
        a2 = boot + 32'd8;
        do_reset(s, boot, m13);
        push_exp(boot, 1); push_exp(a1, 1);
        en = 1'b1; auto_gnt = 1; auto_rvalid = 1; rstn = 1'b1;
        settle_stalled("fill");
        check("head_valid", 32'(dv_m), 32'd1);
        check("head_pc", dp_m, boot);
        check("head_instr", di_m, data_fn(boot, m13));
        push_exp(a2, 1);
        dec_ready = 1'b1;
        @(posedge clk); #1;
        dec_ready = 1'b0;
        settle_stalled("pulse");
        drain("stream");
    endtask

    initial begin
        bit found;

        // Zero-wait stream of NOPs from 0, and wrapping stream from the high boot address.
        run_stream(1'b0, 32'h0, 1'b1);
        run_stream(1'b1, HiBoot, 1'b0);

        // Grant withheld five cycles, redirect in cycle 2: address held, response dropped.
        do_reset(1'b0, 32'h0, 1'b0);
        push_exp(32'h0, 0); push_exp(32'h100, 1); push_exp(32'h104, 1);
        en = 1'b1; rstn = 1'b1; auto_rvalid = 1;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(posedge clk); #1;
            found = req_m;
        end
        check("req_rise", 32'(found), 32'd1);
        for (int i = 1; i <= 5; i++) begin
            if (i > 1) begin @(posedge clk); #1; end
            jmp = (i == 2); jmp_addr = 32'h100;
            check("held_addr", addr_m, 32'h0);
            check("held_req", 32'(req_m), 32'd1);
        end
        auto_gnt = 1;
        settle_stalled("redirect_req");
        drain("redirect_req");

        // Redirect while waiting for data to a misaligned target.
        do_reset(1'b0, 32'h0, 1'b0);
        push_exp(32'h0, 0); push_exp(32'h200, 1); push_exp(32'h204, 1);
        en = 1'b1; auto_gnt = 1; rstn = 1'b1;
        wait_hs("wait_jmp");
        jmp = 1'b1; jmp_addr = 32'h203;
        @(posedge clk); #1;
        jmp = 1'b0; auto_rvalid = 1;
        check("wait_jmp_dv", 32'(dv_m), 32'd0);
        settle_stalled("wait_jmp");
        check("wait_jmp_head", dp_m, 32'h200);
        drain("wait_jmp");

        // Redirect coinciding with rvalid while the buffer holds an entry: all discarded.
        do_reset(1'b0, 32'h0, 1'b0);
        push_exp(32'h0, 0); push_exp(32'h4, 0); push_exp(32'h40, 1); push_exp(32'h44, 1);
        en = 1'b1; auto_gnt = 1; auto_rvalid = 1; rstn = 1'b1;
        wait_hs("prio0");
        wait_hs("prio4");
        check("prio_dv_before", 32'(dv_m), 32'd1);
        jmp = 1'b1; jmp_addr = 32'h40;
        @(posedge clk); #1;
        jmp = 1'b0;
        check("prio_dv_after", 32'(dv_m), 32'd0);
        settle_stalled("prio");
        drain("prio");

        // Reset pulse during WAIT, stale rvalid right after it must be ignored.
        do_reset(1'b0, 32'h0, 1'b0);
        push_exp(32'h0, 0); push_exp(32'h0, 1); push_exp(32'h4, 1);
        en = 1'b1; auto_gnt = 1; rstn = 1'b1;
        wait_hs("mid_reset");
        rstn = 1'b0; auto_rvalid = 1;
        #1;
        check("async_rst_req", 32'(req_m), 32'd0);
        check("async_rst_addr", addr_m, 32'h0);
        #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        check("stale_rv_dv", 32'(dv_m), 32'd0);
        check("stale_rv_req", 32'(req_m), 32'd0);
        settle_stalled("mid_reset");
        drain("mid_reset");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passes, checks);
        $fatal(1);
    end

endmodule
